// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract done one nibble per clock through a single 4-bit ripple adder.
// Operands are latched on start; result, carry-out and signed overflow are registered on completion.

module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0][3:0]  a_q, b_q, shadow_q, full_sum;
    logic               carry_q;
    logic [IW-1:0]      idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q, ovf_q;
    logic [3:0]         add_s;
    logic               add_co;
    logic               last;

    ripple_carry_adder_4bit u_add (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_s),
        .cout (add_co)
    );

    assign last = (idx_q == IW'(N - 1));

    // Shadow with the in-flight nibble merged, so the final edge can publish a complete result.
    always_comb begin
        full_sum        = shadow_q;
        full_sum[idx_q] = add_s;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~op_b : op_b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    shadow_q[idx_q] <= add_s;
                    carry_q         <= add_co;
                    if (last) begin
                        idx_q  <= '0;
                        sum_q  <= full_sum;
                        cout_q <= add_co;
                        // Sign of result disagrees with two like-signed addends.
                        ovf_q  <= (a_q[N-1][3] == b_q[N-1][3]) &&
                                  (full_sum[N-1][3] != a_q[N-1][3]);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed checks of the serial adder at WIDTH=16 and WIDTH=4
// against an integer-arithmetic reference model.

module tb_nibble_serial_adder_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        start16, cin16, sub16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        start4, cin4, sub4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op_a(a16), .op_b(b16),
        .cin(cin16), .sub(sub16), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op_a(a4), .op_b(b4),
        .cin(cin4), .sub(sub4), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned for carry/borrow, signed range for overflow.
    function automatic void model(input int w, input longint a, input longint b, input bit ci,
                                  input bit sb, output longint s, output bit co, output bit ov);
        longint full, sa, sbv, sr, half;
        half = 64'sd1 <<< (w - 1);
        sa   = (a >= half) ? a - 2 * half : a;
        sbv  = (b >= half) ? b - 2 * half : b;
        if (sb) begin
            full = a - b;
            co   = (a >= b);
            sr   = sa - sbv;
        end else begin
            full = a + b + longint'(ci);
            co   = ((full >>> w) & 1) != 0;
            sr   = sa + sbv + longint'(ci);
        end
        s  = full & (2 * half - 1);
        ov = (sr > half - 1) || (sr < -half);
    endfunction

    function automatic logic mux_busy(input bit w4);
        return w4 ? busy4 : busy16;
    endfunction
    function automatic logic mux_done(input bit w4);
        return w4 ? done4 : done16;
    endfunction

    // Runs one operation on the selected DUT; returns observed results.
    task automatic run_op(input bit w4, input logic [15:0] a, input logic [15:0] b,
                          input bit ci, input bit sb, input string tag,
                          output logic [15:0] rs, output logic rco, output logic rov);
        int     lat;
        longint es;
        bit     eco, eov;
        @(negedge clk);
        if (w4) begin
            start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; cin4 = ci; sub4 = sb;
        end else begin
            start16 = 1'b1; a16 = a; b16 = b; cin16 = ci; sub16 = sb;
        end
        @(negedge clk);
        start4 = 1'b0; start16 = 1'b0;
        chk({tag, ".busy_acc"}, 32'(mux_busy(w4)), 32'd1);
        lat = 1;
        while (!mux_done(w4) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), w4 ? 32'd2 : 32'd5);
        rs  = w4 ? {12'b0, sum4} : sum16;
        rco = w4 ? cout4 : cout16;
        rov = w4 ? ovf4 : ovf16;
        model(w4 ? 4 : 16, longint'(w4 ? {12'b0, a[3:0]} : a), longint'(w4 ? {12'b0, b[3:0]} : b),
              ci, sb, es, eco, eov);
        chk({tag, ".sum"}, 32'(rs), 32'(es));
        chk({tag, ".cout"}, 32'(rco), 32'(eco));
        chk({tag, ".ovf"}, 32'(rov), 32'(eov));
        @(negedge clk);
        chk({tag, ".done_w"}, 32'(mux_done(w4)), 32'd0);
        chk({tag, ".busy_end"}, 32'(mux_busy(w4)), 32'd0);
    endtask

    typedef struct {
        logic [15:0] a, b;
        bit ci, sb, w4;
        logic [15:0] es;
        bit eco, eov;
    } vec_t;

    initial begin
        vec_t        dir[$];
        logic [15:0] rs;
        logic        rco, rov;
        int          cnt;
        bit          seen;

        rst = 1'b1;
        start16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0;
        start4 = 0;  a4 = 0;  b4 = 0;  cin4 = 0;  sub4 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst.busy", 32'(busy16), 32'd0);
        chk("rst.done", 32'(done16), 32'd0);
        chk("rst.sum", 32'(sum16), 32'd0);
        chk("rst.cout_ovf", {30'd0, cout16, ovf16}, 32'd0);
        chk("rst4.sum", {28'd0, sum4}, 32'd0);

        dir.push_back('{16'h1234, 16'h4321, 0, 0, 0, 16'h5555, 0, 0});
        dir.push_back('{16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 1, 0});
        dir.push_back('{16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 0, 1});
        dir.push_back('{16'h000F, 16'h0000, 1, 0, 0, 16'h0010, 0, 0});
        dir.push_back('{16'h0005, 16'h0007, 0, 1, 0, 16'hFFFE, 0, 0});
        dir.push_back('{16'h8000, 16'h0001, 0, 1, 0, 16'h7FFF, 1, 1});
        dir.push_back('{16'h0005, 16'h0007, 1, 1, 0, 16'hFFFE, 0, 0});
        dir.push_back('{16'h8000, 16'h0001, 1, 1, 0, 16'h7FFF, 1, 1});
        dir.push_back('{16'h0009, 16'h0008, 0, 0, 1, 16'h0001, 1, 1});
        foreach (dir[i]) begin
            run_op(dir[i].w4, dir[i].a, dir[i].b, dir[i].ci, dir[i].sb, $sformatf("dir%0d", i),
                   rs, rco, rov);
            chk($sformatf("dir%0d.const", i), {14'd0, rco, rov, rs},
                {14'd0, dir[i].eco, dir[i].eov, dir[i].es});
        end

        for (int i = 0; i < 40; i++)
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   $sformatf("rnd16_%0d", i), rs, rco, rov);
        for (int i = 0; i < 20; i++)
            run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   $sformatf("rnd4_%0d", i), rs, rco, rov);

        // Start pulses during RUN and DONE must be ignored.
        @(negedge clk);
        start16 = 1; a16 = 16'h1111; b16 = 16'h2222; cin16 = 0; sub16 = 0;
        @(negedge clk);
        start16 = 0;
        @(negedge clk);
        start16 = 1; a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1;
        @(negedge clk);
        start16 = 0;
        cnt = 0;
        while (!done16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("ign.done", 32'(done16), 32'd1);
        chk("ign.sum", 32'(sum16), 32'h3333);
        start16 = 1;
        @(negedge clk);
        start16 = 0;
        chk("ign.busy_after", 32'(busy16), 32'd0);
        @(negedge clk);
        chk("ign.busy_idle", 32'(busy16), 32'd0);
        chk("ign.sum_hold", 32'(sum16), 32'h3333);

        // Start held high: back-to-back operations, one every N+2 cycles.
        start16 = 1; a16 = 16'h0101; b16 = 16'h0202; cin16 = 0; sub16 = 0;
        cnt = 0;
        while (!done16 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("b2b.first", 32'(done16), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!done16 && cnt < 20);
            chk($sformatf("b2b%0d.period", k), 32'(cnt), 32'd6);
            chk($sformatf("b2b%0d.sum", k), 32'(sum16), 32'h0303);
        end
        start16 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b.idle", 32'(busy16), 32'd0);

        // Reset after the second RUN edge aborts the operation.
        start16 = 1; a16 = 16'h1234; b16 = 16'h1111;
        @(negedge clk);
        start16 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort.busy", 32'(busy16), 32'd0);
        chk("abort.sum", 32'(sum16), 32'd0);
        chk("abort.cout_ovf", {30'd0, cout16, ovf16}, 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done16 || busy16) seen = 1;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        run_op(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, "post_rst", rs, rco, rov);
        chk("post_rst.const", {15'd0, rco, rs}, {15'd0, 1'b0, 16'h1000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequential controller that performs a WIDTH-bit add or subtract by time-multiplexing a single `ripple_carry_adder_4bit` instance, one nibble per clock, least-significant nibble first. It latches operands on a start handshake, carries between nibbles in a register, and presents a registered result with carry-out and signed overflow. This block is the area-saving wide adder path for datapaths that would otherwise need WIDTH/4 adder stages.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only on a rising edge where busy=0
- op_a  input  WIDTH  operand A, sampled at acceptance
- op_b  input  WIDTH  operand B, sampled at acceptance
- cin  input  1  carry-in for add, sampled at acceptance; ignored when sub=1
- sub  input  1  0 = A+B+cin, 1 = A−B (A + ~B + 1), sampled at acceptance
- busy  output  1  high while an operation is in progress (RUN or DONE)
- done  output  1  one-cycle pulse; result outputs valid from this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

## Operation
- Exactly one `ripple_carry_adder_4bit` instance; no other adders in the block.
- States: IDLE, RUN, DONE.
- IDLE: busy=0. If start=1, latch op_a into A register, op_b (or ~op_b when sub=1) into B register, carry register ← (sub ? 1 : cin), nibble index ← 0, state → RUN.
- RUN: adder inputs are nibble[index] of A and B registers plus carry register. Each edge: write adder Sum into result shadow nibble[index], carry register ← adder Cout, index ← index+1. On the edge processing index N−1: load sum ← completed shadow (including the final nibble), cout ← adder Cout, ovf ← (A[W−1] == Beff[W−1]) && (sum[W−1] != A[W−1]), with Beff being the latched (possibly inverted) B; state → DONE.
- DONE: done=1, busy=1 for exactly one cycle; next edge → IDLE unconditionally.
- sum, cout and ovf change only on the edge entering DONE and hold until the next DONE or reset.
- start while busy=1 (RUN or DONE) is ignored and has no side effects; operands are not re-sampled.
- Nibble index wraps never: width is ceil(log2(N)) bits, or 1 bit minimum when N=1.

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0; internal registers 0.
- rst has priority over everything, including a simultaneous start; asserting rst mid-RUN or in DONE aborts the operation: no done pulse, outputs return to 0.
- Acceptance at edge k → busy=1 from after edge k; nibbles processed on edges k+1 … k+N; done=1 in the cycle after edge k+N; busy=0 after edge k+N+1.
- Start-to-done latency is N+1 edges; throughput is one operation per N+2 cycles. A start held high through DONE is accepted on the first edge seen in IDLE.
- N=1: one RUN edge, then DONE.

## Test plan
- WIDTH=16, add 0x1234 + 0x4321, cin=0 → sum=0x5555, cout=0, ovf=0; done asserted exactly 5 edges after acceptance, one cycle wide.
- Add 0xFFFF + 0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. Add 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1. Add 0x000F + 0x0000, cin=1 → sum=0x0010, showing carry propagation across a nibble boundary.
- Sub 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1. Drive cin=1 with sub=1 and confirm the result is unchanged.
- Accept 0x1111+0x2222, then pulse start with 0xAAAA+0x5555 during RUN and during DONE → both pulses are ignored; sum=0x3333. Hold start high continuously → operations are accepted back-to-back, each in the cycle after DONE.
- Assert rst for one cycle after the second RUN edge → busy=0, done never pulses, and sum/cout/ovf read 0. The next operation, 0x0F0F + 0x00F1, gives sum=0x1000, cout=0.
- WIDTH=4 instance: 0x9 + 0x8 → sum=0x1, cout=1, ovf=1; done asserted 2 edges after acceptance.
